// File: rtl/gb_video_pkg.sv
// Shared Game Boy video constants: LCD geometry, DVI raster size, shade type, default palette.
package gb_video_pkg;
   localparam int GB_W      = 160;
   localparam int GB_H      = 144;
   localparam int GB_PIXELS = GB_W * GB_H;
   localparam int RASTER_W  = 640;
   localparam int RASTER_H  = 480;
   localparam int ADDR_W    = 15;

   typedef logic [1:0] shade_t;

   localparam logic [23:0] PAL0_DEF = 24'hFFFFFF;
   localparam logic [23:0] PAL1_DEF = 24'hAAAAAA;
   localparam logic [23:0] PAL2_DEF = 24'h555555;
   localparam logic [23:0] PAL3_DEF = 24'h000000;
endpackage

// File: rtl/gb_frame_ram.sv
// 23040 x 2-bit simple dual-port frame store, registered read, read-first on collision.
module gb_frame_ram
   import gb_video_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  shade_t            i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output shade_t            o_rdata
);
   shade_t r_mem [GB_PIXELS];

   // Both accesses use NBAs, so a same-address read sees the pre-write contents.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end
endmodule

// File: rtl/gb_lcd_scaler.sv
// Captures the Game Boy 160x144 shade stream and replays it integer-scaled and centred
// in the 640x480 raster as 8-bit RGB, two fbclk cycles after x/y/border.
module gb_lcd_scaler
   import gb_video_pkg::*;
#(
   parameter int          SCALE  = 3,
   parameter int          X_OFF  = 80,
   parameter int          Y_OFF  = 24,
   parameter logic [23:0] PAL0   = PAL0_DEF,
   parameter logic [23:0] PAL1   = PAL1_DEF,
   parameter logic [23:0] PAL2   = PAL2_DEF,
   parameter logic [23:0] PAL3   = PAL3_DEF,
   parameter logic [23:0] BG_RGB = 24'h000000
) (
   input  logic        fbclk,
   input  logic        fbclk_rst_b,
   input  logic        gb_frame_start,
   input  logic        gb_pix_valid,
   input  logic [1:0]  gb_pix_data,
   input  logic [11:0] x,
   input  logic [11:0] y,
   input  logic        border,
   output logic [7:0]  red_p,
   output logic [7:0]  green_p,
   output logic [7:0]  blue_p,
   output logic        overrun,
   output logic        frame_ready
);
   localparam logic [ADDR_W-1:0] PIX_N   = ADDR_W'(GB_PIXELS);
   localparam logic [ADDR_W-1:0] PIX_END = ADDR_W'(GB_PIXELS - 1);
   localparam logic [11:0] X_LO = 12'(X_OFF);
   localparam logic [11:0] X_HI = 12'(X_OFF + GB_W * SCALE);
   localparam logic [11:0] Y_LO = 12'(Y_OFF);
   localparam logic [11:0] Y_HI = 12'(Y_OFF + GB_H * SCALE);
   localparam logic [1:0]  SUB_END = 2'(SCALE - 1);

   logic [ADDR_W-1:0] r_wptr;
   logic              r_overrun, r_frame_ready;
   logic [7:0]        r_col, r_row;
   logic [1:0]        r_hsub, r_vsub;
   logic [ADDR_W-1:0] r_rbase;
   logic              r_win1;
   logic [23:0]       r_rgb;

   logic              w_we, w_full, w_in_win, w_hwrap, w_vwrap;
   logic [ADDR_W-1:0] w_waddr, w_raddr;
   logic [7:0]        w_col, w_col_nx;
   logic [1:0]        w_hsub;
   shade_t            w_rdata;

   // ---------------- write side ----------------
   assign w_full  = (r_wptr == PIX_N);
   assign w_we    = gb_pix_valid && (gb_frame_start || !w_full);
   assign w_waddr = gb_frame_start ? '0 : r_wptr;

   always_ff @(posedge fbclk or negedge fbclk_rst_b) begin
      if (!fbclk_rst_b) begin
         r_wptr        <= '0;
         r_overrun     <= 1'b0;
         r_frame_ready <= 1'b0;
      end else begin
         if (gb_frame_start) begin
            r_wptr    <= gb_pix_valid ? ADDR_W'(1) : '0;
            r_overrun <= 1'b0;
         end else if (gb_pix_valid) begin
            if (w_full) r_overrun <= 1'b1;
            else        r_wptr    <= r_wptr + ADDR_W'(1);
         end
         if (w_we && w_waddr == PIX_END) r_frame_ready <= 1'b1;
      end
   end

   // ---------------- read address generation ----------------
   assign w_in_win = !border && (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
   // The first window column reads col 0 in the same cycle it loads the counters.
   assign w_col    = (x == X_LO) ? 8'd0 : r_col;
   assign w_hsub   = (x == X_LO) ? 2'd0 : r_hsub;
   assign w_hwrap  = (w_hsub == SUB_END);
   assign w_col_nx = (w_col == 8'(GB_W - 1)) ? 8'd0 : w_col + 8'd1;
   assign w_vwrap  = (r_vsub == SUB_END);
   assign w_raddr  = r_rbase + ADDR_W'(w_col);

   always_ff @(posedge fbclk or negedge fbclk_rst_b) begin
      if (!fbclk_rst_b) begin
         r_col   <= '0;
         r_hsub  <= '0;
         r_row   <= '0;
         r_vsub  <= '0;
         r_rbase <= '0;
      end else begin
         if (w_in_win) begin
            r_hsub <= w_hwrap ? 2'd0 : w_hsub + 2'd1;
            r_col  <= w_hwrap ? w_col_nx : w_col;
         end else if (x == X_LO) begin
            r_col  <= '0;
            r_hsub <= '0;
         end
         // Line-rate update at column 0, well before the window opens.
         if (x == 12'd0) begin
            if (y == Y_LO) begin
               r_row   <= '0;
               r_vsub  <= '0;
               r_rbase <= '0;
            end else if (y > Y_LO && y < Y_HI) begin
               if (w_vwrap) begin
                  r_vsub  <= '0;
                  r_row   <= r_row + 8'd1;
                  r_rbase <= r_rbase + ADDR_W'(GB_W);
               end else begin
                  r_vsub  <= r_vsub + 2'd1;
               end
            end
         end
      end
   end

   gb_frame_ram u_ram (
      .i_clk   (fbclk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (gb_pix_data),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   // ---------------- palette / output stage ----------------
   always_ff @(posedge fbclk or negedge fbclk_rst_b) begin
      if (!fbclk_rst_b) begin
         r_win1 <= 1'b0;
         r_rgb  <= BG_RGB;
      end else begin
         r_win1 <= w_in_win;
         if (!r_win1)             r_rgb <= BG_RGB;
         else if (!r_frame_ready) r_rgb <= PAL0;
         else begin
            case (w_rdata)
               2'd0:    r_rgb <= PAL0;
               2'd1:    r_rgb <= PAL1;
               2'd2:    r_rgb <= PAL2;
               default: r_rgb <= PAL3;
            endcase
         end
      end
   end

   assign red_p       = r_rgb[23:16];
   assign green_p     = r_rgb[15:8];
   assign blue_p      = r_rgb[7:0];
   assign overrun     = r_overrun;
   assign frame_ready = r_frame_ready;
endmodule

// File: tb/tb_gb_lcd_scaler.sv
// Scoreboard bench: each cycle's expected RGB is queued from a frame-store model and
// popped two cycles later against the DUT output.
module tb_gb_lcd_scaler;
   import gb_video_pkg::*;

   logic        fbclk = 1'b0;
   logic        fbclk_rst_b = 1'b0;
   logic        gb_frame_start = 1'b0;
   logic        gb_pix_valid = 1'b0;
   logic [1:0]  gb_pix_data = 2'd0;
   logic [11:0] x = 12'd700;
   logic [11:0] y = 12'd500;
   logic        border = 1'b0;
   logic [7:0]  red_p, green_p, blue_p;
   logic        overrun, frame_ready;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 fbclk = ~fbclk;

   gb_lcd_scaler dut (
      .fbclk          (fbclk),
      .fbclk_rst_b    (fbclk_rst_b),
      .gb_frame_start (gb_frame_start),
      .gb_pix_valid   (gb_pix_valid),
      .gb_pix_data    (gb_pix_data),
      .x              (x),
      .y              (y),
      .border         (border),
      .red_p          (red_p),
      .green_p        (green_p),
      .blue_p         (blue_p),
      .overrun        (overrun),
      .frame_ready    (frame_ready)
   );

   typedef struct {
      logic [23:0] rgb;
      int          xv;
      int          yv;
   } exp_t;

   exp_t       q[$];
   logic [1:0] m_mem [GB_PIXELS];
   int         m_wptr = 0;
   bit         m_fr = 1'b0;

   function automatic logic [23:0] pal(input logic [1:0] s);
      case (s)
         2'd0:    return 24'hFFFFFF;
         2'd1:    return 24'hAAAAAA;
         2'd2:    return 24'h555555;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic logic [23:0] model_rgb(input int xv, input int yv, input bit bv);
      if (!bv && xv >= 80 && xv < 560 && yv >= 24 && yv < 456) begin
         if (!m_fr) return 24'hFFFFFF;
         return pal(m_mem[((yv - 24) / 3) * 160 + (xv - 80) / 3]);
      end
      return 24'h000000;
   endfunction

   task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] want);
      n_tests++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // One clock of stimulus; expectation is taken before the model write (read-first).
   task automatic step(input int xv, input int yv, input bit bv = 1'b0, input bit fs = 1'b0,
                       input bit wv = 1'b0, input logic [1:0] wd = 2'd0);
      exp_t e;
      x = 12'(xv); y = 12'(yv); border = bv;
      gb_frame_start = fs; gb_pix_valid = wv; gb_pix_data = wd;
      e.rgb = model_rgb(xv, yv, bv); e.xv = xv; e.yv = yv;
      q.push_back(e);
      if (fs) m_wptr = 0;
      if (wv && m_wptr < GB_PIXELS) begin
         m_mem[m_wptr] = wd;
         if (m_wptr == GB_PIXELS - 1) m_fr = 1'b1;
         m_wptr++;
      end
      @(posedge fbclk); #1;
      gb_frame_start = 1'b0; gb_pix_valid = 1'b0;
      if (q.size() >= 2) begin
         e = q.pop_front();
         n_tests++;
         assert ({red_p, green_p, blue_p} === e.rgb) else begin
            n_fail++;
            $error("FAIL rgb x=%0d y=%0d: got %h expected %h", e.xv, e.yv,
                   {red_p, green_p, blue_p}, e.rgb);
         end
      end
   endtask

   initial begin
      repeat (3) @(posedge fbclk);
      #1;
      chk("rst_rgb", {red_p, green_p, blue_p}, 24'h000000);
      chk("rst_overrun", {23'd0, overrun}, 24'd0);
      chk("rst_frame_ready", {23'd0, frame_ready}, 24'd0);
      @(negedge fbclk) fbclk_rst_b = 1'b1;
      @(posedge fbclk); #1;

      // No frame yet: window shows blank white, x=79 is background.
      step(0, 24);
      for (int xx = 79; xx <= 86; xx++) step(xx, 24);
      step(700, 500);

      // Full frame load, shade = (col+row)%4.
      for (int i = 0; i < GB_PIXELS; i++) begin
         step(700, 500, 1'b0, (i == 0), 1'b1, 2'(((i % 160) + (i / 160)) % 4));
         if (i == GB_PIXELS - 2) chk("frame_ready_early", {23'd0, frame_ready}, 24'd0);
      end
      chk("frame_ready_load", {23'd0, frame_ready}, 24'd1);
      chk("overrun_load", {23'd0, overrun}, 24'd0);

      // 23041st valid is dropped.
      step(700, 500, 1'b0, 1'b0, 1'b1, 2'd3);
      chk("overrun_set", {23'd0, overrun}, 24'd1);

      // Raster sweep; line 24 also restarts a frame and collides on address 5.
      for (int yy = 23; yy <= 456; yy++) begin
         step(0, yy);
         if (yy inside {23, 24, 25, 26, 27, 100, 455, 456}) begin
            for (int xx = 79; xx <= 560; xx++) begin
               if (yy == 24 && xx == 90)                 step(xx, yy, 1'b0, 1'b1, 1'b1, 2'd2);
               else if (yy == 24 && xx > 90 && xx <= 95) step(xx, yy, 1'b0, 1'b0, 1'b1, 2'd3);
               else                                      step(xx, yy, (yy == 100 && xx == 559));
            end
         end
         if (yy == 24) chk("overrun_clear", {23'd0, overrun}, 24'd0);
      end
      step(700, 500);

      // Stream a new frame while reading address 0, then reset mid-stream.
      step(0, 24);
      for (int i = 0; i < 10000; i++) step(80, 24, 1'b0, (i == 0), 1'b1, 2'((i % 3) + 1));
      #1 fbclk_rst_b = 1'b0;
      #1;
      chk("async_rst_rgb", {red_p, green_p, blue_p}, 24'h000000);
      chk("async_rst_frame_ready", {23'd0, frame_ready}, 24'd0);
      chk("async_rst_overrun", {23'd0, overrun}, 24'd0);
      q.delete();
      m_wptr = 0; m_fr = 1'b0;
      @(negedge fbclk) fbclk_rst_b = 1'b1;
      @(posedge fbclk); #1;

      step(0, 24);
      for (int xx = 80; xx <= 83; xx++) step(xx, 24);
      step(700, 500);
      for (int i = 0; i < GB_PIXELS; i++) begin
         step(700, 500, 1'b0, (i == 0), 1'b1, 2'(i % 4));
         if (i == GB_PIXELS - 2) chk("frame_ready_after_rst_early", {23'd0, frame_ready}, 24'd0);
      end
      chk("frame_ready_after_rst", {23'd0, frame_ready}, 24'd1);
      step(700, 500);
      step(700, 500);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
